// File: rtl/gp_cmd_proc.sv
`timescale 1ns/1ps
`default_nettype none
// gp_cmd_proc: walks a CPU-built command list and dispatches FILL/LINE commands to the engines.
// Optional GP_CMD_STATS_EN adds saturating fill/line handshake counters.  Rev 1.0
module gp_cmd_proc #(
   parameter int COORD_W  = 10,
   parameter int MAX_CMDS = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [31:0]        cmd_addr,
   input  logic [31:0]        fb_base,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [31:0]        mem_req_addr,
   input  logic               mem_rdata_valid,
   input  logic [31:0]        mem_rdata,
   output logic               fill_valid,
   input  logic               fill_ready,
   output logic [23:0]        fill_color,
   output logic               line_valid,
   input  logic               line_ready,
   output logic [COORD_W-1:0] line_x0,
   output logic [COORD_W-1:0] line_y0,
   output logic [COORD_W-1:0] line_x1,
   output logic [COORD_W-1:0] line_y1,
   output logic [23:0]        line_color,
   output logic [31:0]        eng_fb_base,
   output logic               busy,
   output logic               done,
`ifdef GP_CMD_STATS_EN
   output logic [15:0]        lines_issued,
   output logic [15:0]        fills_issued,
`endif
   output logic               err
);

   localparam int CNT_W = $clog2(MAX_CMDS + 1);
   localparam logic [CNT_W-1:0] CMD_LIMIT = CNT_W'(MAX_CMDS);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_WAIT, S_DECODE, S_ISSUE_FILL, S_ISSUE_LINE, S_DONE
   } state_t;

   typedef enum logic [1:0] {PH_CMD, PH_P0, PH_P1} phase_t;

   state_t             state_q, state_d;
   phase_t             phase_q, phase_d;
   logic [31:0]        ptr_q, ptr_d;
   logic [31:0]        fb_q, fb_d;
   logic [31:0]        cmd_q, cmd_d;
   logic [31:0]        p0_q, p0_d;
   logic [31:0]        p1_q, p1_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
`ifdef GP_CMD_STATS_EN
   logic [15:0]        fills_q, fills_d;
   logic [15:0]        lines_q, lines_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         phase_q <= PH_CMD;
         ptr_q   <= '0;
         fb_q    <= '0;
         cmd_q   <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef GP_CMD_STATS_EN
         fills_q <= '0;
         lines_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ptr_q   <= ptr_d;
         fb_q    <= fb_d;
         cmd_q   <= cmd_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef GP_CMD_STATS_EN
         fills_q <= fills_d;
         lines_q <= lines_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      ptr_d   = ptr_q;
      fb_d    = fb_q;
      cmd_d   = cmd_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
`ifdef GP_CMD_STATS_EN
      fills_d = fills_q;
      lines_d = lines_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d   = {cmd_addr[31:2], 2'b00};
               fb_d    = fb_base;
               err_d   = 1'b0;
               cnt_d   = '0;
               phase_d = PH_CMD;
               state_d = S_REQ;
`ifdef GP_CMD_STATS_EN
               fills_d = '0;
               lines_d = '0;
`endif
            end
         end
         S_REQ: begin
            if (mem_req_ready) begin
               ptr_d   = ptr_q + 32'd4;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rdata_valid) begin
               case (phase_q)
                  PH_CMD: begin
                     cmd_d   = mem_rdata;
                     state_d = S_DECODE;
                  end
                  PH_P0: begin
                     p0_d    = mem_rdata;
                     phase_d = PH_P1;
                     state_d = S_REQ;
                  end
                  default: begin
                     p1_d    = mem_rdata;
                     state_d = S_ISSUE_LINE;
                  end
               endcase
            end
         end
         S_DECODE: begin
            // The limit is checked before the word is executed, so the word is dropped.
            if (cnt_q == CMD_LIMIT) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               case (cmd_q[31:24])
                  8'h00:   state_d = S_DONE;
                  8'h01:   state_d = S_ISSUE_FILL;
                  8'h02: begin
                     phase_d = PH_P0;
                     state_d = S_REQ;
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_ISSUE_FILL: begin
            if (fill_ready) begin
               phase_d = PH_CMD;
               state_d = S_REQ;
`ifdef GP_CMD_STATS_EN
               if (fills_q != 16'hFFFF) fills_d = fills_q + 16'd1;
`endif
            end
         end
         S_ISSUE_LINE: begin
            if (line_ready) begin
               phase_d = PH_CMD;
               state_d = S_REQ;
`ifdef GP_CMD_STATS_EN
               if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Valids are gated by rst so they fall in the very cycle reset is applied.
   assign mem_req_valid = rst && (state_q == S_REQ);
   assign mem_req_addr  = ptr_q;
   assign fill_valid    = rst && (state_q == S_ISSUE_FILL);
   assign fill_color    = cmd_q[23:0];
   assign line_valid    = rst && (state_q == S_ISSUE_LINE);
   assign line_color    = cmd_q[23:0];
   assign line_x0       = p0_q[16 +: COORD_W];
   assign line_y0       = p0_q[COORD_W-1:0];
   assign line_x1       = p1_q[16 +: COORD_W];
   assign line_y1       = p1_q[COORD_W-1:0];
   assign eng_fb_base   = fb_q;
   assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done          = (state_q == S_DONE);
   assign err           = err_q;

`ifdef GP_CMD_STATS_EN
   assign fills_issued  = fills_q;
   assign lines_issued  = lines_q;
`else
   // Statistics counters are not built in this configuration.
`endif

   logic unused_bits;
   assign unused_bits = ^{cmd_addr[1:0], p0_q[31:16+COORD_W], p0_q[15:COORD_W],
                          p1_q[31:16+COORD_W], p1_q[15:COORD_W]};

endmodule
`default_nettype wire

// File: tb/tb_gp_cmd_proc.sv
`timescale 1ns/1ps
`default_nettype none
// tb_gp_cmd_proc: randomized command lists checked against a transaction-level list model.
module tb_gp_cmd_proc;
   localparam int CW   = 10;
   localparam int MAXC = 4;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic [31:0] cmd_addr = '0, fb_base = '0;
   logic mem_req_valid, mem_req_ready = 1'b0;
   logic [31:0] mem_req_addr;
   logic mem_rdata_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic fill_valid, fill_ready = 1'b0;
   logic [23:0] fill_color;
   logic line_valid, line_ready = 1'b0;
   logic [CW-1:0] line_x0, line_y0, line_x1, line_y1;
   logic [23:0] line_color;
   logic [31:0] eng_fb_base;
   logic busy, done, err;
`ifdef GP_CMD_STATS_EN
   logic [15:0] lines_issued, fills_issued;
`endif

   gp_cmd_proc #(.COORD_W(CW), .MAX_CMDS(MAXC)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd_addr(cmd_addr), .fb_base(fb_base),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_color(fill_color),
      .line_valid(line_valid), .line_ready(line_ready),
      .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
      .line_color(line_color), .eng_fb_base(eng_fb_base), .busy(busy), .done(done),
`ifdef GP_CMD_STATS_EN
      .lines_issued(lines_issued), .fills_issued(fills_issued),
`endif
      .err(err));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int cyc = 0, resp_at = -1, last_resp_cyc = 0, done_cnt = 0;
   int lat_min = 0, lat_max = 0, req_pct = 100, fill_pct = 100, line_pct = 100;
   logic [31:0] resp_data;
   logic [31:0] mem [logic [31:0]];

   logic [31:0] exp_rd[$], obs_rd[$];
   logic [23:0] exp_fill[$], obs_fill[$];
   logic [63:0] exp_line[$], obs_line[$];
   logic        exp_err;
   logic [31:0] exp_fb;
   int          exp_nfill, exp_nline;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   function automatic void put(input logic [31:0] a, input logic [31:0] d);
      mem[a] = d;
   endfunction

   function automatic logic [63:0] lpack(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
      longint m;
      m = longint'(1) << CW;
      return (64'(c % 32'h0100_0000) << (4*CW)) | (64'((a >> 16) % m) << (3*CW)) |
             (64'(a % m) << (2*CW)) | (64'((b >> 16) % m) << CW) | 64'(b % m);
   endfunction

   // Walk the list the way the specification describes it, producing whole transactions.
   function automatic void build_model(input logic [31:0] a);
      logic [31:0] p, w, q0, q1;
      int n, op;
      exp_rd.delete(); exp_fill.delete(); exp_line.delete();
      exp_err = 1'b0; exp_nfill = 0; exp_nline = 0;
      p = a & 32'hFFFF_FFFC;
      n = 0;
      while (1) begin
         w = rd(p); exp_rd.push_back(p); p = p + 32'd4;
         if (n == MAXC) begin exp_err = 1'b1; break; end
         n++;
         op = int'(w >> 24);
         if (op == 0) break;
         else if (op == 1) begin exp_fill.push_back(w[23:0]); exp_nfill++; end
         else if (op == 2) begin
            q0 = rd(p); exp_rd.push_back(p); p = p + 32'd4;
            q1 = rd(p); exp_rd.push_back(p); p = p + 32'd4;
            exp_line.push_back(lpack(w, q0, q1)); exp_nline++;
         end else begin exp_err = 1'b1; break; end
      end
   endfunction

   // Input driver: random readies, memory responses, spurious strobes outside a pending read.
   initial begin
      forever begin
         @(posedge clk); cyc++; #1;
         mem_req_ready = ($urandom_range(99) < req_pct);
         fill_ready    = ($urandom_range(99) < fill_pct);
         line_ready    = ($urandom_range(99) < line_pct);
         if (resp_at == cyc) begin
            mem_rdata_valid = 1'b1; mem_rdata = resp_data; resp_at = -1; last_resp_cyc = cyc;
         end else begin
            mem_rdata_valid = (resp_at < 0) && ($urandom_range(9) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   logic prev_rst = 1'b0, prev_mv = 1'b0, prev_mr = 1'b0, prev_fv = 1'b0, prev_fr = 1'b0;
   logic prev_lv = 1'b0, prev_lr = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [23:0] prev_fc = '0;
   logic [63:0] prev_lp = '0;
   logic [63:0] cur_lp;

   always @(negedge clk) begin
      cur_lp = {line_color, line_x0, line_y0, line_x1, line_y1};
      if (!rst)
         check("valids_in_reset", {61'd0, mem_req_valid, fill_valid, line_valid}, 64'd0);
      if (rst && prev_rst) begin
         if (prev_mv && !prev_mr) begin
            check("req_hold_valid", mem_req_valid, 1);
            check("req_hold_addr", mem_req_addr, prev_addr);
         end
         if (prev_fv && !prev_fr) begin
            check("fill_hold_valid", fill_valid, 1);
            check("fill_hold_color", fill_color, prev_fc);
         end
         if (prev_lv && !prev_lr) begin
            check("line_hold_valid", line_valid, 1);
            check("line_hold_payload", cur_lp, prev_lp);
         end
      end
      if (rst) begin
         check("fill_line_exclusive", fill_valid & line_valid, 0);
         if (fill_valid && !prev_fv)
            check("fill_latency", (cyc - last_resp_cyc) <= 3, 1);
         if (mem_req_valid && mem_req_ready) begin
            obs_rd.push_back(mem_req_addr);
            check("read_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) check("read_addr", mem_req_addr, exp_rd.pop_front());
            resp_data = rd(mem_req_addr);
            resp_at = cyc + 1 + int'($urandom_range(lat_max, lat_min));
         end
         if (fill_valid && fill_ready) begin
            obs_fill.push_back(fill_color);
            check("fill_expected", exp_fill.size() != 0, 1);
            if (exp_fill.size() != 0) check("fill_color", fill_color, exp_fill.pop_front());
            check("fill_fb_base", eng_fb_base, exp_fb);
         end
         if (line_valid && line_ready) begin
            obs_line.push_back(cur_lp);
            check("line_expected", exp_line.size() != 0, 1);
            if (exp_line.size() != 0) check("line_payload", cur_lp, exp_line.pop_front());
            check("line_fb_base", eng_fb_base, exp_fb);
         end
         if (done) begin
            check("done_err", err, exp_err);
            check("done_busy", busy, 0);
            check("done_reads_left", exp_rd.size(), 0);
            check("done_fills_left", exp_fill.size(), 0);
            check("done_lines_left", exp_line.size(), 0);
`ifdef GP_CMD_STATS_EN
            check("stats_fills", fills_issued, exp_nfill);
            check("stats_lines", lines_issued, exp_nline);
`endif
            done_cnt++;
         end
      end
      prev_rst = rst; prev_mv = mem_req_valid; prev_mr = mem_req_ready; prev_addr = mem_req_addr;
      prev_fv = fill_valid; prev_fr = fill_ready; prev_fc = fill_color;
      prev_lv = line_valid; prev_lr = line_ready; prev_lp = cur_lp;
   end

   task automatic do_start(input logic [31:0] a, input logic [31:0] fb);
      build_model(a); exp_fb = fb;
      obs_rd.delete(); obs_fill.delete(); obs_line.delete();
      @(posedge clk); #1; cmd_addr = a; fb_base = fb; start = 1'b1;
      @(posedge clk); #1; start = 1'b0; cmd_addr = $urandom; fb_base = $urandom;
      @(negedge clk);
      check("start_clears_err", err, 0);
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input int budget);
      int n, d0;
      n = 0; d0 = done_cnt;
      while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
      check("done_within_budget", done_cnt != d0, 1);
      repeat (2) @(posedge clk);
   endtask

   task automatic put_line_list(input logic [31:0] a);
      mem.delete();
      put(a, 32'h0200FFFF); put(a + 4, 32'h0); put(a + 8, 32'h03200258); put(a + 12, 32'h0);
   endtask

   initial begin
      logic [31:0] a, p;
      int n, k, w;
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, p;
      int n, k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_err", err, 0);
      check("rst_req_addr", mem_req_addr, 0); check("rst_fb", eng_fb_base, 0);
      check("rst_fill_color", fill_color, 0);
      @(posedge clk); #1; rst = 1'b1;

      // Single fill then STOP, zero-wait memory.
      mem.delete(); put(32'h10400000, 32'h0100FFFF); put(32'h10400004, 32'h0);
      do_start(32'h10400000, 32'hA000_0000); wait_done(200);
      check("t1_reads", obs_rd.size(), 2);
      if (obs_rd.size() == 2) begin
         check("t1_rd0", obs_rd[0], 32'h10400000); check("t1_rd1", obs_rd[1], 32'h10400004);
      end
      check("t1_fills", obs_fill.size(), 1);
      if (obs_fill.size() == 1) check("t1_color", obs_fill[0], 24'h00FFFF);
      check("t1_err", err, 0);

      // Line list, with a start pulse while busy that must be ignored.
      put_line_list(32'h0000_2000);
      do_start(32'h0000_2003, 32'h1234_5678);
      #1; cmd_addr = 32'h5000; start = 1'b1; @(posedge clk); #1; start = 1'b0;
      wait_done(200);
      check("t2_lines", obs_line.size(), 1);
      if (obs_line.size() == 1)
         check("t2_payload", obs_line[0], {24'h00FFFF, 10'd0, 10'd0, 10'd800, 10'd600});

      // Line engine stalls for 20 cycles.
      put_line_list(32'h0000_3000);
      line_pct = 0;
      do_start(32'h0000_3000, 32'h0);
      n = 0;
      while (!line_valid && n < 200) begin @(negedge clk); n++; end
      check("t3_line_seen", line_valid, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t3_line_held", line_valid, 1);
         check("t3_no_req", mem_req_valid, 0);
      end
      line_pct = 100;
      wait_done(200);

      // Unknown opcode, then a clean run clears err.
      mem.delete(); put(32'h0000_4000, 32'h7F000000);
      do_start(32'h0000_4000, 32'h0); wait_done(200);
      check("t4_err", err, 1);
      check("t4_no_engine", obs_fill.size() + obs_line.size(), 0);
      mem.delete(); put(32'h10400000, 32'h0100FFFF);
      do_start(32'h10400000, 32'h0); wait_done(200);

      // Reset while waiting on memory; the late response must be ignored.
      mem.delete(); put(32'h0000_5000, 32'h01123456);
      lat_min = 6; lat_max = 6;
      do_start(32'h0000_5000, 32'h0);
      n = 0;
      while (resp_at < 0 && n < 200) begin @(negedge clk); n++; end
      check("t5_req_seen", resp_at >= 0, 1);
      @(posedge clk); #1; rst = 1'b0;
      repeat (2) @(posedge clk); #1; rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t5_idle", {61'd0, busy, fill_valid | line_valid, mem_req_valid}, 64'd0);
      end
      lat_min = 0; lat_max = 0;
      mem.delete(); put(32'h0000_5100, 32'h01ABCDEF);
      do_start(32'h0000_5100, 32'h0); wait_done(200);
      check("t5_clean_fills", obs_fill.size(), 1);

      // Five fills, no STOP: command limit aborts after four.
      mem.delete();
      for (int i = 0; i < 5; i++) put(32'h0000_6000 + 32'(4*i), 32'h01000001 + 32'(i));
      do_start(32'h0000_6000, 32'h0); wait_done(200);
      check("t6_fills", obs_fill.size(), 4);
      check("t6_reads", obs_rd.size(), 5);
      check("t6_err", err, 1);
`ifdef GP_CMD_STATS_EN
      check("t6_stats", fills_issued, 16'd4);
`endif

      // Randomized lists, including address wrap and random handshake pressure.
      for (int t = 0; t < 40; t++) begin
         mem.delete();
         if ($urandom_range(3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(15));
         else a = $urandom;
         p = a & 32'hFFFF_FFFC;
         n = $urandom_range(6);
         for (int i = 0; i < n; i++) begin
            k = $urandom_range(9);
            if (k < 5) begin put(p, {8'h01, 24'($urandom)}); p = p + 4; end
            else if (k < 9) begin
               put(p, {8'h02, 24'($urandom)}); put(p + 4, $urandom); put(p + 8, $urandom);
               p = p + 12;
            end else begin put(p, {8'($urandom_range(255, 3)), 24'($urandom)}); p = p + 4; end
         end
         if ($urandom_range(1) == 1) put(p, {8'h00, 24'($urandom)});
         req_pct = $urandom_range(100, 30); fill_pct = $urandom_range(100, 30);
         line_pct = $urandom_range(100, 30); lat_max = $urandom_range(3);
         do_start(a, $urandom); wait_done(3000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gp_cmd_proc.md
Name: gp_cmd_proc

Overview:
- Graphics command processor front end, directly downstream of the CPU program that builds command lists in memory.
- The CPU writes the frame-buffer base and the command-list pointer, then pulses start.
- The block walks the list word by word through a single-outstanding memory read port, decodes fill and line commands, and hands them to the fill and line engines over valid/ready.
- It stops on a STOP opcode, an unknown opcode, or a command-count limit.

Parameters:
- COORD_W, 10, width of each x/y coordinate passed to the line engine.
- MAX_CMDS, 4096, maximum commands decoded per list before forced abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- start  in  1  one-cycle pulse; latch cmd_addr/fb_base and begin walking list
- cmd_addr  in  32  byte address of first command word; bits [1:0] ignored
- fb_base  in  32  frame-buffer base, forwarded unchanged to engines
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned byte address of request
- mem_rdata_valid  in  1  read data return strobe
- mem_rdata  in  32  returned word
- fill_valid  out  1  fill command valid
- fill_ready  in  1  fill engine accepts
- fill_color  out  24  RGB fill colour
- line_valid  out  1  line command valid
- line_ready  in  1  line engine accepts
- line_x0, line_y0, line_x1, line_y1  out  COORD_W each  endpoints
- line_color  out  24  RGB line colour
- eng_fb_base  out  32  latched fb_base
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at list end
- err  out  1  sticky; set on unknown opcode or MAX_CMDS overflow; cleared by next accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; pointer, counters, latched values cleared.
- Command word format: [31:24] opcode, [23:0] colour.
  - 0x00 = STOP.
  - 0x01 = FILL, 1 word.
  - 0x02 = LINE, 3 words: cmd, then P0, then P1.
  - Point word: x = [16+COORD_W-1:16], y = [COORD_W-1:0]; upper bits ignored.
- States: IDLE, REQ, WAIT, DECODE, ISSUE_FILL, ISSUE_LINE, DONE.
- IDLE: on start=1, latch ptr = {cmd_addr[31:2],2'b00}, latch eng_fb_base, clear err and cmd count, go REQ. start while not IDLE is ignored.
- REQ:
  - Assert mem_req_valid with mem_req_addr = ptr.
  - mem_req_valid and mem_req_addr stay stable until mem_req_ready.
  - On handshake: ptr += 4 (modulo 2^32 wrap), go WAIT.
- WAIT:
  - Deassert mem_req_valid.
  - On mem_rdata_valid, capture the word into the slot for the current phase (cmd, P0 or P1).
  - Go DECODE after a cmd word. After P0, go REQ for P1. After P1, go ISSUE_LINE.
- DECODE: increment cmd count.
  - STOP: go DONE.
  - FILL: go ISSUE_FILL.
  - LINE: go REQ for P0.
  - Other opcode: set err, go DONE.
  - If count reaches MAX_CMDS before decoding: set err, go DONE (the word is not executed).
- ISSUE_FILL / ISSUE_LINE:
  - Hold valid plus payload stable until ready.
  - Return to REQ the cycle after the handshake.
  - valid and ready both high in the same cycle counts as accepted.
- DONE: pulse done for 1 cycle, go IDLE. busy is low in IDLE and DONE.
- Latency: a fill with zero-wait memory reaches fill_valid 3 cycles after rdata_valid of its cmd word at most.
- Only one read is outstanding. mem_rdata_valid outside WAIT is ignored.
- Reset mid-operation:
  - Abort immediately to IDLE; all valids drop in the same cycle reset is sampled.
  - Late rdata after reset is ignored.
- fill_valid and line_valid are never high together.

Optional Feature:
- Macro GP_CMD_STATS_EN.
- When defined, adds outputs lines_issued[15:0] and fills_issued[15:0].
  - Each increments on its respective engine handshake and saturates at 0xFFFF.
  - Both clear on reset and on accepted start.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- List at 0x10400000: [0x0100FFFF, 0x00000000], memory 0-wait -> one fill_valid with fill_color=0x00FFFF; done pulse; err=0; exactly 2 read requests (0x10400000, 0x10400004).
- Line list [0x0200FFFF, 0x00000000, 0x03200258, 0x0] -> line_valid with x0=0, y0=0, x1=800, y1=600, color=0x00FFFF; then done.
- Line engine holds line_ready=0 for 20 cycles -> line_valid and payload stable throughout; no new mem_req_valid until handshake.
- Opcode 0x7F as first word -> err=1, done pulse, no fill/line valid; next start clears err.
- Reset asserted (rst=0) while in WAIT, then mem_rdata_valid arrives -> state IDLE, busy=0, no engine valid; a new start runs cleanly.
- MAX_CMDS=4, list of 5 fills with no STOP -> 4 fills issued, err=1, done; with GP_CMD_STATS_EN, fills_issued=4.
